// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared constants for the pipeline stall controller: FSM encoding, flush counter
// width and the bit order of the packed control-output vector.
package pipeline_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StFlush  = 2'd1,
        StFreeze = 2'd2
    } state_e;

    localparam int unsigned FlushCntW = 3;

    // Bit positions of {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_advance, watchdog_err}
    localparam int unsigned OutPcWrite   = 5;
    localparam int unsigned OutIfidWrite = 4;
    localparam int unsigned OutIfidFlush = 3;
    localparam int unsigned OutBubble    = 2;
    localparam int unsigned OutAdvance   = 1;
    localparam int unsigned OutWdErr     = 0;

endpackage

// File: rtl/stall_watchdog.sv
// Counts consecutive load-use stall cycles and raises a sticky error once the run
// reaches MAX_STALL. A held (frozen) cycle neither advances nor clears the run.
module stall_watchdog #(
    parameter int unsigned MAX_STALL = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic stall,
    input  logic hold,
    output logic err
);

    localparam int unsigned RunW = $clog2(MAX_STALL + 1);
    localparam logic [RunW-1:0] MaxRun  = RunW'(MAX_STALL);
    localparam logic [RunW-1:0] LastRun = RunW'(MAX_STALL - 1);

    logic [RunW-1:0] stall_run_q, stall_run_d;
    logic            err_q, err_d;
    logic            hit;

    // Run length and sticky error next-state; hit makes the error visible in the
    // very cycle the run reaches MAX_STALL.
    always_comb begin
        stall_run_d = stall_run_q;
        hit         = stall && !hold && (stall_run_q >= LastRun);
        if (hold) begin
            stall_run_d = stall_run_q;
        end else if (stall) begin
            stall_run_d = (stall_run_q == MaxRun) ? stall_run_q : stall_run_q + 1'b1;
        end else begin
            stall_run_d = '0;
        end
        err_d = err_q | hit;
        err   = err_q | hit;
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_run_q <= '0;
            err_q       <= 1'b0;
        end else begin
            stall_run_q <= stall_run_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Hazard arbiter for the 5-stage pipeline: turns load-use, branch and memory-wait
// requests into stage-register enables with same-cycle (Mealy) response.
// Optional statistics counters are built when HAZARD_STATS_EN is defined.
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_SLOTS = 1,
    parameter int unsigned MAX_STALL   = 15
`ifdef HAZARD_STATS_EN
    , parameter int unsigned CNT_W     = 32
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_use_stall,
    input  logic             branch_taken,
    input  logic             mem_wait,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             pipe_advance,
    output logic             watchdog_err
`ifdef HAZARD_STATS_EN
    , output logic [CNT_W-1:0] stall_cycles
    , output logic [CNT_W-1:0] flush_cycles
`endif
);

    localparam logic [FlushCntW-1:0] ReloadCnt = FlushCntW'(FLUSH_SLOTS - 1);

    state_e                 state_q, state_d;
    state_e                 ret_state_q, ret_state_d;
    logic [FlushCntW-1:0]   flush_cnt_q, flush_cnt_d;
    logic                   branch_pend_q, branch_pend_d;
    logic                   stall_eff;
    logic                   wd_err;
    state_e                 eff_state;

    // Arbitration, next state and Mealy output decode.
    always_comb begin
        state_d       = state_q;
        ret_state_d   = ret_state_q;
        flush_cnt_d   = flush_cnt_q;
        branch_pend_d = branch_pend_q;
        pc_write      = 1'b1;
        ifid_write    = 1'b1;
        ifid_flush    = 1'b0;
        idex_bubble   = 1'b0;
        pipe_advance  = 1'b1;
        stall_eff     = 1'b0;
        // On the cycle leaving FREEZE we act on the state that was interrupted.
        eff_state     = (state_q == StFreeze) ? ret_state_q : state_q;

        if (mem_wait) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            pipe_advance = 1'b0;
            if (state_q != StFreeze) begin
                ret_state_d = state_q;
                state_d     = StFreeze;
            end
            if (branch_taken) begin
                branch_pend_d = 1'b1;
            end
        end else if (branch_taken || branch_pend_q) begin
            ifid_write    = 1'b0;
            ifid_flush    = 1'b1;
            idex_bubble   = 1'b1;
            branch_pend_d = 1'b0;
            if (FLUSH_SLOTS > 1) begin
                state_d     = StFlush;
                flush_cnt_d = ReloadCnt;
            end else begin
                state_d = StRun;
            end
        end else if (eff_state == StFlush) begin
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            flush_cnt_d = flush_cnt_q - 1'b1;
            state_d     = (flush_cnt_q == 1) ? StRun : StFlush;
        end else if (load_use_stall) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            stall_eff   = 1'b1;
            state_d     = StRun;
        end else begin
            state_d = StRun;
        end

        watchdog_err = wd_err;

        // Reset forces the safe output pattern combinationally.
        if (!rst_n) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            ifid_flush   = 1'b0;
            idex_bubble  = 1'b1;
            pipe_advance = 1'b0;
            watchdog_err = 1'b0;
            stall_eff    = 1'b0;
        end
    end

    // FSM and pending-redirect registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StRun;
            ret_state_q   <= StRun;
            flush_cnt_q   <= '0;
            branch_pend_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ret_state_q   <= ret_state_d;
            flush_cnt_q   <= flush_cnt_d;
            branch_pend_q <= branch_pend_d;
        end
    end

    stall_watchdog #(
        .MAX_STALL(MAX_STALL)
    ) u_stall_watchdog (
        .clk  (clk),
        .rst_n(rst_n),
        .stall(stall_eff),
        .hold (mem_wait),
        .err  (wd_err)
    );

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_cycles_q, flush_cycles_d;

    // Saturating event counters.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_cycles_d = flush_cycles_q;
        if (stall_eff && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + 1'b1;
        end
        if (ifid_flush && (flush_cycles_q != '1)) begin
            flush_cycles_d = flush_cycles_q + 1'b1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
            flush_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_cycles_q <= flush_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_cycles = flush_cycles_q;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl with FLUSH_SLOTS=3, MAX_STALL=15.
// Output vector order: {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_advance, watchdog_err}.
module tb_pipeline_stall_ctrl;

    localparam logic [5:0] VRst   = 6'b000100;
    localparam logic [5:0] VRun   = 6'b110010;
    localparam logic [5:0] VStall = 6'b000110;
    localparam logic [5:0] VBr    = 6'b101110;
    localparam logic [5:0] VFrz   = 6'b000000;

    logic clk = 1'b0;
    logic rst_n;
    logic load_use_stall, branch_taken, mem_wait;
    logic pc_write, ifid_write, ifid_flush, idex_bubble, pipe_advance, watchdog_err;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles, flush_cycles;
`endif

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(
        .FLUSH_SLOTS(3),
        .MAX_STALL  (15)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .load_use_stall(load_use_stall),
        .branch_taken  (branch_taken),
        .mem_wait      (mem_wait),
        .pc_write      (pc_write),
        .ifid_write    (ifid_write),
        .ifid_flush    (ifid_flush),
        .idex_bubble   (idex_bubble),
        .pipe_advance  (pipe_advance),
        .watchdog_err  (watchdog_err)
`ifdef HAZARD_STATS_EN
        , .stall_cycles(stall_cycles)
        , .flush_cycles(flush_cycles)
`endif
    );

    logic [5:0] outv;
    assign outv = {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_advance, watchdog_err};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply inputs for one cycle, check outputs mid-cycle, end just after the next edge.
    task automatic step(input string tag, input logic lu, input logic br, input logic mw,
                        input logic [5:0] exp);
        load_use_stall = lu;
        branch_taken   = br;
        mem_wait       = mw;
        @(negedge clk);
        check_eq(tag, {26'd0, outv}, {26'd0, exp});
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        load_use_stall = 1'b0;
        branch_taken   = 1'b0;
        mem_wait       = 1'b0;
        @(negedge clk);
        check_eq("reset_outputs", {26'd0, outv}, {26'd0, VRst});
`ifdef HAZARD_STATS_EN
        check_eq("reset_stall_cnt", stall_cycles, 32'd0);
        check_eq("reset_flush_cnt", flush_cycles, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Idle
        for (int i = 0; i < 3; i++) step("idle", 1'b0, 1'b0, 1'b0, VRun);

        // Single load-use stall
        step("lu_stall", 1'b1, 1'b0, 1'b0, VStall);
        step("lu_after", 1'b0, 1'b0, 1'b0, VRun);
`ifdef HAZARD_STATS_EN
        check_eq("stall_cnt_1", stall_cycles, 32'd1);
`endif

        // Branch with load-use held: three flush cycles, stall ignored
        step("br_lu_0", 1'b1, 1'b1, 1'b0, VBr);
        step("br_lu_1", 1'b1, 1'b0, 1'b0, VBr);
        step("br_lu_2", 1'b1, 1'b0, 1'b0, VBr);
        step("br_lu_end", 1'b0, 1'b0, 1'b0, VRun);
`ifdef HAZARD_STATS_EN
        check_eq("flush_cnt_3", flush_cycles, 32'd3);
        check_eq("stall_cnt_still_1", stall_cycles, 32'd1);
`endif

        // mem_wait 4 cycles, branch in cycle 2 becomes pending
        step("frz_1", 1'b0, 1'b0, 1'b1, VFrz);
        step("frz_2_br", 1'b0, 1'b1, 1'b1, VFrz);
        step("frz_3", 1'b0, 1'b0, 1'b1, VFrz);
        step("frz_4", 1'b0, 1'b0, 1'b1, VFrz);
        step("frz_exit_br", 1'b0, 1'b0, 1'b0, VBr);
        step("frz_flush_1", 1'b0, 1'b0, 1'b0, VBr);
        step("frz_flush_2", 1'b0, 1'b0, 1'b0, VBr);
        step("frz_run", 1'b0, 1'b0, 1'b0, VRun);

        // Branch coincident with mem_wait rising
        step("coinc_frz", 1'b0, 1'b1, 1'b1, VFrz);
        step("coinc_br", 1'b0, 1'b0, 1'b0, VBr);
        step("coinc_fl1", 1'b0, 1'b0, 1'b0, VBr);
        step("coinc_fl2", 1'b0, 1'b0, 1'b0, VBr);
        step("coinc_run", 1'b0, 1'b0, 1'b0, VRun);

        // Freeze in the middle of a flush preserves remaining slots
        step("mid_br", 1'b0, 1'b1, 1'b0, VBr);
        step("mid_frz1", 1'b1, 1'b0, 1'b1, VFrz);
        step("mid_frz2", 1'b0, 1'b0, 1'b1, VFrz);
        step("mid_fl1", 1'b1, 1'b0, 1'b0, VBr);
        step("mid_fl2", 1'b0, 1'b0, 1'b0, VBr);
        step("mid_run", 1'b0, 1'b0, 1'b0, VRun);
`ifdef HAZARD_STATS_EN
        check_eq("flush_cnt_12", flush_cycles, 32'd12);
`endif

        // Watchdog: 15 consecutive stalls
        for (int i = 1; i <= 14; i++) step("wd_stall", 1'b1, 1'b0, 1'b0, VStall);
        step("wd_hit", 1'b1, 1'b0, 1'b0, VStall | 6'b000001);
        step("wd_sticky_1", 1'b0, 1'b0, 1'b0, VRun | 6'b000001);
        step("wd_sticky_2", 1'b0, 1'b0, 1'b0, VRun | 6'b000001);
`ifdef HAZARD_STATS_EN
        check_eq("stall_cnt_16", stall_cycles, 32'd16);
`endif

        // Reset asserted while flush_cnt=2
        step("rst_br", 1'b0, 1'b1, 1'b0, VBr | 6'b000001);
        branch_taken = 1'b0;
        @(negedge clk);
        check_eq("rst_flush2", {26'd0, outv}, {26'd0, VBr | 6'b000001});
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_immediate", {26'd0, outv}, {26'd0, VRst});
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("post_rst_1", 1'b0, 1'b0, 1'b0, VRun);
        step("post_rst_2", 1'b0, 1'b0, 1'b0, VRun);
`ifdef HAZARD_STATS_EN
        check_eq("post_rst_flush_cnt", flush_cycles, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
